// File: rtl/tpu_load_sequencer_if.sv
// Byte-pair valid/ready channel from the host/SPI side into the TPU load sequencer.
interface tpu_load_sequencer_if #(
  parameter int unsigned D_W = 8
);
  logic [D_W-1:0] byte_x;
  logic [D_W-1:0] byte_y;
  logic           byte_valid;
  logic           byte_ready;

  modport master (output byte_x, output byte_y, output byte_valid, input byte_ready);
  modport slave  (input byte_x, input byte_y, input byte_valid, output byte_ready);
endinterface

// File: rtl/tpu_load_sequencer.sv
// Serializes N*N host byte pairs LSB-first into the TPU input stage, then runs init/compute/done.
// Optional recompute-on-loaded-operands path enabled by defining TPU_SEQ_RERUN_EN.
module tpu_load_sequencer #(
  parameter int unsigned D_W         = 8,
  parameter int unsigned N           = 2,
  parameter int unsigned COMPUTE_CYC = 3 * N + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rerun,
  tpu_load_sequencer_if.slave   host,
  output logic                  load_en,
  output logic                  data_in_x,
  output logic                  data_in_y,
  output logic                  init,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int unsigned PAIRS  = N * N;
  localparam int unsigned BYTE_W = $clog2(PAIRS + 1);
  localparam int unsigned BIT_W  = (D_W > 1) ? $clog2(D_W) : 1;
  localparam int unsigned CYC_W  = $clog2(COMPUTE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LEAD, S_SHIFT, S_TAIL, S_INIT, S_COMPUTE, S_ERR
  } state_t;

  state_t            state, state_n;
  logic [D_W-1:0]    shift_x, shift_y, shift_x_n, shift_y_n;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [CYC_W-1:0]  cyc_cnt, cyc_cnt_n;
  logic              load_en_d, data_x_d, data_y_d, init_d, busy_d, done_d, err_d;
  logic              last_bit, more_bytes, handshake;

  assign last_bit   = (bit_cnt == BIT_W'(D_W - 1));
  assign more_bytes = (byte_cnt < BYTE_W'(PAIRS - 1));

  // Ready is the only combinational output: FETCH, or the last bit of a non-final pair.
  assign host.byte_ready = (state == S_FETCH) || ((state == S_SHIFT) && last_bit && more_bytes);
  assign handshake       = host.byte_ready && host.byte_valid;

`ifndef TPU_SEQ_RERUN_EN
  logic unused_rerun;
  assign unused_rerun = rerun;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_FETCH;
`ifdef TPU_SEQ_RERUN_EN
        else if (rerun) state_n = S_INIT;
`endif
      end
      S_FETCH:   if (handshake) state_n = S_LEAD;
      S_LEAD:    state_n = S_SHIFT;
      S_SHIFT: begin
        if (last_bit) begin
          if (!more_bytes)           state_n = S_TAIL;
          else if (!host.byte_valid) state_n = S_ERR;
        end
      end
      S_TAIL:    state_n = S_INIT;
      S_INIT:    state_n = S_COMPUTE;
      // Leaving on the count of 2 puts done exactly COMPUTE_CYC cycles after init.
      S_COMPUTE: if (cyc_cnt <= CYC_W'(2)) state_n = S_IDLE;
      S_ERR:     state_n = S_ERR;
      default:   state_n = S_IDLE;
    endcase
  end

  // Shift registers and counters, next values.
  always_comb begin
    shift_x_n  = shift_x;
    shift_y_n  = shift_y;
    byte_cnt_n = byte_cnt;
    bit_cnt_n  = bit_cnt;
    cyc_cnt_n  = cyc_cnt;
    unique case (state)
      S_FETCH: begin
        if (handshake) begin
          shift_x_n  = host.byte_x;
          shift_y_n  = host.byte_y;
          byte_cnt_n = '0;
          bit_cnt_n  = '0;
        end
      end
      S_SHIFT: begin
        shift_x_n = shift_x >> 1;
        shift_y_n = shift_y >> 1;
        bit_cnt_n = last_bit ? '0 : bit_cnt + BIT_W'(1);
        if (handshake) begin
          shift_x_n  = host.byte_x;
          shift_y_n  = host.byte_y;
          byte_cnt_n = byte_cnt + BYTE_W'(1);
        end
      end
      S_INIT:    cyc_cnt_n = CYC_W'(COMPUTE_CYC);
      S_COMPUTE: cyc_cnt_n = cyc_cnt - CYC_W'(1);
      default: ;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up with it.
  always_comb begin
    load_en_d = (state_n == S_LEAD) || (state_n == S_SHIFT);
    data_x_d  = (state_n == S_SHIFT) && shift_x_n[0];
    data_y_d  = (state_n == S_SHIFT) && shift_y_n[0];
    init_d    = (state_n == S_INIT);
    busy_d    = (state_n != S_IDLE) && (state_n != S_ERR);
    done_d    = (state == S_COMPUTE) && (state_n == S_IDLE);
    err_d     = (state_n == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_x   <= '0;
      shift_y   <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      cyc_cnt   <= '0;
      load_en   <= 1'b0;
      data_in_x <= 1'b0;
      data_in_y <= 1'b0;
      init      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      shift_x   <= shift_x_n;
      shift_y   <= shift_y_n;
      byte_cnt  <= byte_cnt_n;
      bit_cnt   <= bit_cnt_n;
      cyc_cnt   <= cyc_cnt_n;
      load_en   <= load_en_d;
      data_in_x <= data_x_d;
      data_in_y <= data_y_d;
      init      <= init_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end
endmodule

// File: tb/tb_tpu_load_sequencer.sv
// Self-checking bench for tpu_load_sequencer: per-cycle traces compared against a timeline model.
module tb_tpu_load_sequencer;
  localparam int unsigned D_W = 8;
  localparam int unsigned N   = 2;
  localparam int unsigned NP  = N * N;
  localparam int unsigned C   = 3 * N + 2;

  logic clk, rst, start, rerun;
  logic load_en, data_in_x, data_in_y, init, busy, done, err;
  int checks, errors;
  logic [D_W-1:0] px [NP];
  logic [D_W-1:0] py [NP];

  tpu_load_sequencer_if #(.D_W(D_W)) bus ();

  tpu_load_sequencer #(.D_W(D_W), .N(N), .COMPUTE_CYC(C)) dut (
    .clk(clk), .rst(rst), .start(start), .rerun(rerun), .host(bus),
    .load_en(load_en), .data_in_x(data_in_x), .data_in_y(data_in_y),
    .init(init), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {byte_ready, load_en, data_in_x, data_in_y, init, busy, done, err}
  function automatic logic [7:0] sample();
    return {bus.byte_ready, load_en, data_in_x, data_in_y, init, busy, done, err};
  endfunction

  // Expected outputs k cycles after start was sampled, with d stalled FETCH cycles and an
  // underrun when pair e (e>0) is due; e<=0 means no underrun.
  function automatic logic [7:0] exp_at(input int k, input int d, input int e);
    int lead, sh0, tail, ini, dn, kb, b, j;
    logic rdy, le, dx, dy, it, bz, dp, er;
    lead = 2 + d;
    sh0  = lead + 1;
    tail = sh0 + NP * D_W;
    ini  = tail + 1;
    dn   = ini + C;
    kb   = sh0 + e * D_W - 1;
    {rdy, le, dx, dy, it, bz, dp, er} = 8'b0;
    if (e > 0 && k > kb) er = 1'b1;
    else if (k >= 1 && k < lead) begin bz = 1'b1; rdy = 1'b1; end
    else if (k == lead) begin bz = 1'b1; le = 1'b1; end
    else if (k >= sh0 && k < tail) begin
      b = (k - sh0) / D_W;
      j = (k - sh0) % D_W;
      bz = 1'b1; le = 1'b1;
      dx = px[b][j];
      dy = py[b][j];
      rdy = (j == D_W - 1) && (b < NP - 1);
    end
    else if (k == tail) bz = 1'b1;
    else if (k == ini) begin bz = 1'b1; it = 1'b1; end
    else if (k > ini && k < dn) bz = 1'b1;
    else if (k == dn) dp = 1'b1;
    return {rdy, le, dx, dy, it, bz, dp, er};
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NP; i++) begin
      px[i] = D_W'($urandom);
      py[i] = D_W'($urandom);
    end
  endtask

  // Called in the cycle where start is to be sampled (DUT idle); returns in the done cycle
  // (or a few cycles into ERR, or right after an aborting reset).
  task automatic run_job(input int d, input int e, input bit chain, input int abort_k, input int poke_k);
    int hs, end_k, le_cnt, init_k, done_k, done_cnt;
    logic [7:0] obs, ex;
    hs = 0; le_cnt = 0; init_k = -1; done_k = -1; done_cnt = 0;
    end_k = (e > 0) ? (3 + d + e * D_W - 1 + 3) : (3 + d + NP * D_W + 1 + C);
    start = 1'b1; rerun = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_x = px[0]; bus.byte_y = py[0];
    for (int k = 1; k <= end_k; k++) begin
      step();
      obs = sample();
      ex  = exp_at(k, d, e);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL job_trace k=%0d d=%0d e=%0d got=%b exp=%b", k, d, e, obs, ex);
      end
      if (obs[6]) le_cnt++;
      if (obs[3]) init_k = k;
      if (obs[1]) begin done_k = k; done_cnt++; end
      if (k == abort_k) begin
        rst = 1'b1; start = 1'b0; bus.byte_valid = 1'b0;
        step();
        obs = sample();
        checks++;
        if (obs !== 8'b0) begin
          errors++;
          $display("FAIL abort_reset got=%b exp=%b", obs, 8'b0);
        end
        rst = 1'b0;
        return;
      end
      start = (chain && k == end_k) || (k == poke_k);
      bus.byte_valid = (k > d) && !(e > 0 && hs == e);
      if (hs < NP) begin
        bus.byte_x = px[hs];
        bus.byte_y = py[hs];
      end else begin
        bus.byte_x = D_W'($urandom);
        bus.byte_y = D_W'($urandom);
      end
      if (obs[7] && bus.byte_valid) hs++;
    end
    if (e <= 0) begin
      checks++;
      if (le_cnt != NP * D_W + 1) begin
        errors++;
        $display("FAIL load_window got=%0d exp=%0d", le_cnt, NP * D_W + 1);
      end
      checks++;
      if (done_k - init_k != C || done_cnt != 1) begin
        errors++;
        $display("FAIL init_to_done got=%0d dones=%0d exp=%0d dones=1", done_k - init_k, done_cnt, C);
      end
    end else begin
      checks++;
      if (done_cnt != 0) begin
        errors++;
        $display("FAIL underrun_no_done got=%0d exp=0", done_cnt);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string name);
    logic [7:0] obs;
    for (int i = 0; i < n; i++) begin
      step();
      obs = sample();
      checks++;
      if (obs !== 8'b0) begin
        errors++;
        $display("FAIL %s cycle=%0d got=%b exp=%b", name, i, obs, 8'b0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rerun = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_x = '0; bus.byte_y = '0;
    idle_cycles(3, "reset");
    rst = 1'b0;
    idle_cycles(2, "post_reset_idle");
  endtask

  task automatic test_basic_job();
    for (int i = 0; i < NP; i++) begin
      px[i] = D_W'(i + 1);
      py[i] = D_W'((i + 1) * 16);
    end
    run_job(0, -1, 1'b0, -1, -1);
    start = 1'b0;
    idle_cycles(2, "basic_after_done");
  endtask

  task automatic test_random_jobs();
    for (int t = 0; t < 5; t++) begin
      fill_random();
      run_job(int'($urandom_range(0, 3)), -1, 1'b0, -1, -1);
      start = 1'b0;
      idle_cycles(1, "random_gap");
    end
  endtask

  task automatic test_ignored_inputs();
    int ini;
    bus.byte_valid = 1'b1;
    idle_cycles(5, "valid_without_start");
    fill_random();
    ini = 3 + NP * D_W + 1;
    run_job(0, -1, 1'b0, -1, ini + 3);
    start = 1'b0; bus.byte_valid = 1'b0;
    idle_cycles(10, "start_in_compute_ignored");
  endtask

  task automatic test_rerun();
    logic [7:0] obs, ex;
    rerun = 1'b1; start = 1'b0;
    for (int k = 1; k <= int'(C) + 2; k++) begin
      step();
      rerun = 1'b0;
      obs = sample();
      ex  = 8'b0;
`ifdef TPU_SEQ_RERUN_EN
      if (k == 1) ex = 8'b0000_1100;
      else if (k <= int'(C)) ex = 8'b0000_0100;
      else if (k == int'(C) + 1) ex = 8'b0000_0010;
`endif
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL rerun k=%0d got=%b exp=%b", k, obs, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_job(0, -1, 1'b1, -1, -1);
    fill_random();
    run_job(int'($urandom_range(0, 2)), -1, 1'b0, -1, -1);
    start = 1'b0;
    idle_cycles(2, "b2b_after_done");
  endtask

  task automatic test_reset_mid_job();
    int d, ab;
    fill_random();
    d  = int'($urandom_range(0, 2));
    ab = 3 + d + 2 * D_W + int'($urandom_range(0, D_W - 1));
    run_job(d, -1, 1'b0, ab, -1);
    idle_cycles(3, "after_abort");
    fill_random();
    run_job(0, -1, 1'b0, -1, -1);
    start = 1'b0;
  endtask

  task automatic test_underrun();
    logic [7:0] obs;
    for (int t = 0; t < 2; t++) begin
      fill_random();
      run_job(0, (t == 0) ? 1 : int'($urandom_range(1, NP - 1)), 1'b0, -1, -1);
      bus.byte_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        start = (i % 2 == 0);
        step();
        obs = sample();
        checks++;
        if (obs !== 8'b0000_0001) begin
          errors++;
          $display("FAIL err_sticky cycle=%0d got=%b exp=%b", i, obs, 8'b0000_0001);
        end
      end
      start = 1'b0; bus.byte_valid = 1'b0; rst = 1'b1;
      idle_cycles(1, "err_reset");
      rst = 1'b0;
      idle_cycles(1, "err_cleared");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_job();
    test_random_jobs();
    test_ignored_inputs();
    test_rerun();
    test_back_to_back();
    test_reset_mid_job();
    test_underrun();
    fill_random();
    run_job(1, -1, 1'b0, -1, -1);
    start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
